// File: rtl/tlb_pkg.sv
// Shared constants for the CP0 TLB controller: register numbers, write masks,
// FSM state encoding and the MMU write-select encodings.
`timescale 1ns/1ps
package tlb_pkg;

  localparam int TLBNUM_DEF = 16;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  localparam logic [31:0] ENTRYHI_MASK  = 32'hFFFF_E0FF;
  localparam logic [31:0] EHI_VPN2_MASK = 32'hFFFF_E000;
  localparam logic [31:0] ENTRYLO_MASK  = 32'h03FF_FFFF;
  localparam logic [31:0] CTX_PTE_MASK  = 32'hFF80_0000;

  localparam logic [1:0] TLBW_IDLE = 2'b00;
  localparam logic [1:0] TLBW_WI   = 2'b01;
  localparam logic [1:0] TLBW_WR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_PCAP, S_READ, S_RCAP, S_WRITE
  } tlb_state_e;

endpackage

// File: rtl/cp0_random_counter.sv
// CP0 Random register: free-running down counter bounded below by Wired,
// reloading to TLBNUM-1 on reaching Wired or zero, or on any Wired write.
`timescale 1ns/1ps
module cp0_random_counter
  import tlb_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wired_we_i,
  input  logic [IW-1:0] wired_i,
  output logic [IW-1:0] random_o
);

  localparam logic [IW-1:0] RMAX = IW'(TLBNUM - 1);

  logic [IW-1:0] random_q, random_d;

  always_comb begin
    random_d = random_q - 1'b1;
    if (wired_we_i || (wired_i >= RMAX) || (random_q == wired_i) || (random_q == '0))
      random_d = RMAX;
  end

  always_ff @(posedge clk) begin
    if (rst) random_q <= RMAX;
    else     random_q <= random_d;
  end

  assign random_o = random_q;

endmodule

// File: rtl/cp0_tlb_ctrl.sv
// CP0-side TLB controller: CP0 TLB registers plus the TLBP/TLBR/TLBWI/TLBWR sequencer.
// Optional macro CP0_CONTEXT_EN implements the Context register; otherwise it reads 0.
`timescale 1ns/1ps
module cp0_tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_tlbp,
  input  logic        op_tlbr,
  input  logic        op_tlbwi,
  input  logic        op_tlbwr,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  input  logic        tlb_exc,
  input  logic [31:0] tlb_exc_vaddr,
  input  logic [31:0] tlbp_index,
  input  logic [31:0] r_entryhi,
  input  logic [31:0] r_entrylo0,
  input  logic [31:0] r_entrylo1,
  output logic [31:0] c0_index,
  output logic [31:0] c0_random,
  output logic [31:0] c0_entryhi,
  output logic [31:0] c0_entrylo0,
  output logic [31:0] c0_entrylo1,
  output logic [1:0]  tlbw_choose,
  output logic        is_tlbp,
  output logic        busy
);

  localparam int IW = $clog2(TLBNUM);

  tlb_state_e    state_q, state_d;
  logic          wr_rand_q, wr_rand_d;
  logic          index_p_q, index_p_d;
  logic [IW-1:0] index_q, index_d;
  logic [IW-1:0] wired_q, wired_d;
  logic [IW-1:0] random_q;
  logic [31:0]   entryhi_q, entryhi_d;
  logic [31:0]   entrylo0_q, entrylo0_d;
  logic [31:0]   entrylo1_q, entrylo1_d;
  logic [31:0]   badvaddr_q, badvaddr_d;
  logic [31:0]   context_rd;
  logic          idle, wr_en, wired_we;
  logic          unused_tlbp;

  assign idle     = (state_q == S_IDLE);
  // An exception in the same cycle wins over any register write.
  assign wr_en    = mtc0_we && idle && !tlb_exc;
  assign wired_we = wr_en && (mtc0_addr == CP0_WIRED);

  assign unused_tlbp = ^tlbp_index[30:IW];

  cp0_random_counter #(.TLBNUM(TLBNUM)) u_random (
    .clk        (clk),
    .rst        (rst),
    .wired_we_i (wired_we),
    .wired_i    (wired_q),
    .random_o   (random_q)
  );

  always_comb begin
    state_d   = state_q;
    wr_rand_d = wr_rand_q;
    if (tlb_exc) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_tlbp)                  state_d = S_PROBE;
          else if (op_tlbr)             state_d = S_READ;
          else if (op_tlbwi || op_tlbwr) begin
            state_d   = S_WRITE;
            wr_rand_d = op_tlbwr;
          end
        end
        S_PROBE: state_d = S_PCAP;
        S_READ:  state_d = S_RCAP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    is_tlbp     = (state_q == S_PROBE) && !tlb_exc;
    tlbw_choose = TLBW_IDLE;
    if ((state_q == S_WRITE) && !tlb_exc)
      tlbw_choose = wr_rand_q ? TLBW_WR : TLBW_WI;
    busy = !idle;
  end

  always_comb begin
    index_p_d  = index_p_q;
    index_d    = index_q;
    wired_d    = wired_q;
    entryhi_d  = entryhi_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    badvaddr_d = badvaddr_q;
    if (tlb_exc) begin
      badvaddr_d = tlb_exc_vaddr;
      entryhi_d  = (tlb_exc_vaddr & EHI_VPN2_MASK) | (entryhi_q & ~EHI_VPN2_MASK);
    end else if (wr_en) begin
      case (mtc0_addr)
        CP0_INDEX:    index_d    = mtc0_data[IW-1:0];
        CP0_ENTRYLO0: entrylo0_d = mtc0_data & ENTRYLO_MASK;
        CP0_ENTRYLO1: entrylo1_d = mtc0_data & ENTRYLO_MASK;
        CP0_WIRED:    wired_d    = mtc0_data[IW-1:0];
        CP0_ENTRYHI:  entryhi_d  = mtc0_data & ENTRYHI_MASK;
        default: ;
      endcase
    end else if (state_q == S_PCAP) begin
      index_p_d = tlbp_index[31];
      index_d   = tlbp_index[IW-1:0];
    end else if (state_q == S_RCAP) begin
      entryhi_d  = r_entryhi  & ENTRYHI_MASK;
      entrylo0_d = r_entrylo0 & ENTRYLO_MASK;
      entrylo1_d = r_entrylo1 & ENTRYLO_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_rand_q  <= 1'b0;
      index_p_q  <= 1'b0;
      index_q    <= '0;
      wired_q    <= '0;
      entryhi_q  <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      badvaddr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_rand_q  <= wr_rand_d;
      index_p_q  <= index_p_d;
      index_q    <= index_d;
      wired_q    <= wired_d;
      entryhi_q  <= entryhi_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      badvaddr_q <= badvaddr_d;
    end
  end

`ifdef CP0_CONTEXT_EN
  logic [31:0] context_q, context_d;

  // PTEBase is software-written; BadVPN2 is filled only by exceptions.
  always_comb begin
    context_d = context_q;
    if (tlb_exc)
      context_d = {context_q[31:23], tlb_exc_vaddr[31:13], 4'b0};
    else if (wr_en && (mtc0_addr == CP0_CONTEXT))
      context_d = (mtc0_data & CTX_PTE_MASK) | (context_q & ~CTX_PTE_MASK);
  end

  always_ff @(posedge clk) begin
    if (rst) context_q <= '0;
    else     context_q <= context_d;
  end

  assign context_rd = context_q;
`else
  assign context_rd = '0;
`endif

  assign c0_index    = {index_p_q, {(31-IW){1'b0}}, index_q};
  assign c0_random   = 32'(random_q);
  assign c0_entryhi  = entryhi_q;
  assign c0_entrylo0 = entrylo0_q;
  assign c0_entrylo1 = entrylo1_q;

  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
      CP0_INDEX:    mfc0_data = c0_index;
      CP0_RANDOM:   mfc0_data = c0_random;
      CP0_ENTRYLO0: mfc0_data = entrylo0_q;
      CP0_ENTRYLO1: mfc0_data = entrylo1_q;
      CP0_CONTEXT:  mfc0_data = context_rd;
      CP0_WIRED:    mfc0_data = 32'(wired_q);
      CP0_BADVADDR: mfc0_data = badvaddr_q;
      CP0_ENTRYHI:  mfc0_data = entryhi_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Bench for cp0_tlb_ctrl: cycle-level reference model of the CP0 TLB registers
// checked every cycle, plus directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_cp0_tlb_ctrl;

`ifdef CP0_CONTEXT_EN
  localparam bit CTX_EN = 1'b1;
`else
  localparam bit CTX_EN = 1'b0;
`endif
  localparam int NMAX = 15;

  logic        clk, rst;
  logic        op_tlbp, op_tlbr, op_tlbwi, op_tlbwr;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr, mfc0_addr;
  logic [31:0] mtc0_data, mfc0_data;
  logic        tlb_exc;
  logic [31:0] tlb_exc_vaddr, tlbp_index, r_entryhi, r_entrylo0, r_entrylo1;
  logic [31:0] c0_index, c0_random, c0_entryhi, c0_entrylo0, c0_entrylo1;
  logic [1:0]  tlbw_choose;
  logic        is_tlbp, busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  cp0_tlb_ctrl dut (
    .clk(clk), .rst(rst),
    .op_tlbp(op_tlbp), .op_tlbr(op_tlbr), .op_tlbwi(op_tlbwi), .op_tlbwr(op_tlbwr),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
    .tlb_exc(tlb_exc), .tlb_exc_vaddr(tlb_exc_vaddr), .tlbp_index(tlbp_index),
    .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
    .c0_index(c0_index), .c0_random(c0_random), .c0_entryhi(c0_entryhi),
    .c0_entrylo0(c0_entrylo0), .c0_entrylo1(c0_entrylo1),
    .tlbw_choose(tlbw_choose), .is_tlbp(is_tlbp), .busy(busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: op = which instruction is in flight, age = cycles since accepted.
  localparam int OP_NONE = 0, OP_P = 1, OP_R = 2, OP_WI = 3, OP_WR = 4;
  int          m_op = OP_NONE, m_age = 0, m_rand = NMAX, m_wired = 0;
  logic [31:0] m_idx, m_lo0, m_lo1, m_hi, m_bad, m_ctx;
  bit          m_idle;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd0:    return m_idx;
      5'd1:    return 32'(m_rand);
      5'd2:    return m_lo0;
      5'd3:    return m_lo1;
      5'd4:    return CTX_EN ? m_ctx : 32'h0;
      5'd6:    return 32'(m_wired);
      5'd8:    return m_bad;
      5'd10:   return m_hi;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_op = OP_NONE; m_age = 0; m_rand = NMAX; m_wired = 0;
      m_idx = 0; m_lo0 = 0; m_lo1 = 0; m_hi = 0; m_bad = 0; m_ctx = 0;
    end else begin
      m_idle = (m_op == OP_NONE);
      if ((!tlb_exc && m_idle && mtc0_we && mtc0_addr == 5'd6) || m_wired >= NMAX ||
          m_rand == m_wired || m_rand == 0)
        m_rand = NMAX;
      else
        m_rand = m_rand - 1;
      if (tlb_exc) begin
        m_bad = tlb_exc_vaddr;
        m_hi  = (tlb_exc_vaddr & 32'hFFFF_E000) | (m_hi & 32'h0000_00FF);
        m_ctx = (m_ctx & 32'hFF80_0000) | ((tlb_exc_vaddr >> 13) << 4);
        m_op = OP_NONE; m_age = 0;
      end else if (m_idle) begin
        if (mtc0_we) begin
          case (mtc0_addr)
            5'd0:  m_idx = (m_idx & 32'h8000_0000) | (mtc0_data & 32'hF);
            5'd2:  m_lo0 = mtc0_data & 32'h03FF_FFFF;
            5'd3:  m_lo1 = mtc0_data & 32'h03FF_FFFF;
            5'd4:  m_ctx = (mtc0_data & 32'hFF80_0000) | (m_ctx & 32'h007F_FFFF);
            5'd6:  m_wired = int'(mtc0_data & 32'hF);
            5'd10: m_hi  = mtc0_data & 32'hFFFF_E0FF;
            default: ;
          endcase
        end
        if (op_tlbp)       begin m_op = OP_P;  m_age = 1; end
        else if (op_tlbr)  begin m_op = OP_R;  m_age = 1; end
        else if (op_tlbwi) begin m_op = OP_WI; m_age = 1; end
        else if (op_tlbwr) begin m_op = OP_WR; m_age = 1; end
      end else begin
        if (m_op == OP_P && m_age == 2) m_idx = tlbp_index & 32'h8000_000F;
        if (m_op == OP_R && m_age == 2) begin
          m_hi  = r_entryhi  & 32'hFFFF_E0FF;
          m_lo0 = r_entrylo0 & 32'h03FF_FFFF;
          m_lo1 = r_entrylo1 & 32'h03FF_FFFF;
        end
        m_age = m_age + 1;
        if (m_age > ((m_op >= OP_WI) ? 1 : 2)) begin m_op = OP_NONE; m_age = 0; end
      end
    end
  end

  always @(negedge clk) begin
    #40;
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_op != OP_NONE));
      chk("is_tlbp", 32'(is_tlbp), 32'(m_op == OP_P && m_age == 1 && !tlb_exc));
      chk("tlbw_choose", 32'(tlbw_choose),
          tlb_exc ? 32'd0 : (m_op == OP_WI) ? 32'd1 : (m_op == OP_WR) ? 32'd2 : 32'd0);
      chk("c0_index", c0_index, m_idx);
      chk("c0_random", c0_random, 32'(m_rand));
      chk("c0_entryhi", c0_entryhi, m_hi);
      chk("c0_entrylo0", c0_entrylo0, m_lo0);
      chk("c0_entrylo1", c0_entrylo1, m_lo1);
      chk("mfc0_data", mfc0_data, m_read(mfc0_addr));
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    mfc0_addr = a; #1;
    chk(nm, mfc0_data, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_data = d;
    tick();
    mtc0_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_tlbp = 0; op_tlbr = 0; op_tlbwi = 0; op_tlbwr = 0;
    mtc0_we = 0; mtc0_addr = 0; mtc0_data = 0; mfc0_addr = 0;
    tlb_exc = 0; tlb_exc_vaddr = 0; tlbp_index = 0;
    r_entryhi = 0; r_entrylo0 = 0; r_entrylo1 = 0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    rd(5'd0, 32'h0, "rst_index");
    rd(5'd2, 32'h0, "rst_lo0");
    rd(5'd3, 32'h0, "rst_lo1");
    rd(5'd4, 32'h0, "rst_ctx");
    rd(5'd6, 32'h0, "rst_wired");
    rd(5'd8, 32'h0, "rst_badv");
    rd(5'd10, 32'h0, "rst_ehi");
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_choose", 32'(tlbw_choose), 32'h0);
    chk("rst_is_tlbp", 32'(is_tlbp), 32'h0);

    // Random with Wired = 0: 15 .. 0, 15
    for (int i = 0; i < 20; i++) begin
      rd(5'd1, 32'(15 - (i % 16)), "rand_w0");
      tick();
    end

    // Wired = 4: 15 .. 4, 15
    wr(5'd6, 32'd4);
    for (int i = 0; i < 13; i++) begin
      rd(5'd1, (i <= 11) ? 32'(15 - i) : 32'd15, "rand_w4");
      tick();
    end
    for (int n = 0; n < 32 && m_rand != 8; n++) tick();
    op_tlbwr = 1'b1; tick(); op_tlbwr = 1'b0; #1;
    chk("tlbwr_choose", 32'(tlbw_choose), 32'h2);
    chk("tlbwr_random", c0_random, 32'd7);
    tick();
    chk("tlbwr_done_choose", 32'(tlbw_choose), 32'h0);
    chk("tlbwr_done_busy", 32'(busy), 32'h0);

    op_tlbwi = 1'b1; tick(); op_tlbwi = 1'b0; #1;
    chk("tlbwi_choose", 32'(tlbw_choose), 32'h1);
    tick();

    // TLBP hit and miss
    tlbp_index = 32'h0000_0005;
    op_tlbp = 1'b1; tick(); op_tlbp = 1'b0; #1;
    chk("p1_busy", 32'(busy), 32'h1);
    chk("p1_is_tlbp", 32'(is_tlbp), 32'h1);
    tick();
    chk("p2_busy", 32'(busy), 32'h1);
    chk("p2_is_tlbp", 32'(is_tlbp), 32'h0);
    tick();
    chk("p3_busy", 32'(busy), 32'h0);
    rd(5'd0, 32'h0000_0005, "tlbp_hit_index");
    tlbp_index = 32'h8000_0000;
    op_tlbp = 1'b1; tick(); op_tlbp = 1'b0;
    tick(); tick();
    rd(5'd0, 32'h8000_0000, "tlbp_miss_index");

    // TLBR with masks
    r_entryhi = 32'hFFFF_FFFF; r_entrylo0 = 32'hFFFF_FFFF; r_entrylo1 = 32'h1234_5678;
    op_tlbr = 1'b1; tick(); op_tlbr = 1'b0; #1;
    chk("r1_busy", 32'(busy), 32'h1);
    tick(); tick();
    chk("r3_busy", 32'(busy), 32'h0);
    rd(5'd10, 32'hFFFF_E0FF, "tlbr_ehi");
    rd(5'd2, 32'h03FF_FFFF, "tlbr_lo0");
    rd(5'd3, 32'h0234_5678, "tlbr_lo1");

    // Exception address capture
    wr(5'd10, 32'h0000_003C);
    wr(5'd4, 32'hFFFF_FFFF);
    rd(5'd4, CTX_EN ? 32'hFF80_0000 : 32'h0, "ctx_pte_write");
    wr(5'd4, 32'h0);
    tlb_exc_vaddr = 32'h1234_5678; tlb_exc = 1'b1; tick(); tlb_exc = 1'b0;
    rd(5'd8, 32'h1234_5678, "exc_badv");
    rd(5'd10, 32'h1234_403C, "exc_ehi");
    rd(5'd4, CTX_EN ? 32'h0009_1A20 : 32'h0, "exc_ctx");

    // Exception with TLBWI in the same cycle
    tlb_exc_vaddr = 32'h0000_2000;
    op_tlbwi = 1'b1; tlb_exc = 1'b1; #1;
    chk("exc_wi_choose0", 32'(tlbw_choose), 32'h0);
    tick(); op_tlbwi = 1'b0; tlb_exc = 1'b0; #1;
    chk("exc_wi_busy", 32'(busy), 32'h0);
    chk("exc_wi_choose1", 32'(tlbw_choose), 32'h0);
    rd(5'd0, 32'h8000_0000, "exc_wi_index");

    // Exception during PROBE
    tlbp_index = 32'h0000_0003;
    op_tlbp = 1'b1; tick(); op_tlbp = 1'b0;
    tlb_exc = 1'b1; #1;
    chk("exc_p_is_tlbp", 32'(is_tlbp), 32'h0);
    tick(); tlb_exc = 1'b0; #1;
    chk("exc_p_busy", 32'(busy), 32'h0);
    tick(); tick();
    rd(5'd0, 32'h8000_0000, "exc_p_index");

    // Exception during WRITE
    op_tlbwr = 1'b1; tick(); op_tlbwr = 1'b0;
    tlb_exc = 1'b1; #1;
    chk("exc_w_choose", 32'(tlbw_choose), 32'h0);
    tick(); tlb_exc = 1'b0;

    // mtc0 dropped while busy or on exception
    op_tlbr = 1'b1; tick(); op_tlbr = 1'b0;
    mtc0_we = 1'b1; mtc0_addr = 5'd6; mtc0_data = 32'd9; tick(); mtc0_we = 1'b0;
    tick();
    rd(5'd6, 32'd4, "busy_wr_drop");
    mtc0_we = 1'b1; mtc0_addr = 5'd6; mtc0_data = 32'd9; tlb_exc = 1'b1;
    tick(); mtc0_we = 1'b0; tlb_exc = 1'b0;
    rd(5'd6, 32'd4, "exc_wr_drop");

    // Wired at maximum pins Random
    wr(5'd6, 32'd15);
    for (int i = 0; i < 5; i++) begin
      rd(5'd1, 32'd15, "rand_wmax");
      tick();
    end
    wr(5'd6, 32'd0);

    // Masks, read-only and unmapped registers
    tlbp_index = 32'h0000_0002;
    op_tlbp = 1'b1; tick(); op_tlbp = 1'b0; tick(); tick();
    wr(5'd0, 32'hFFFF_FFF7);
    rd(5'd0, 32'h0000_0007, "index_mask");
    wr(5'd3, 32'hFFFF_FFFF);
    rd(5'd3, 32'h03FF_FFFF, "lo1_mask");
    wr(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, 32'h0, "unmapped");
    wr(5'd8, 32'h0);
    rd(5'd8, 32'h0000_2000, "badv_ro");
    wr(5'd1, 32'h0);

    // Reset mid-operation
    op_tlbr = 1'b1; tick(); op_tlbr = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    rd(5'd10, 32'h0, "rst_mid_ehi");
    rd(5'd1, 32'd15, "rst_mid_rand");
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
